// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, classifiers and the accumulator state type.
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_NEG_INF  = 32'hFF80_0000;
    localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;

    typedef enum logic {
        ACC,
        HOLD
    } acc_state_e;

    function automatic logic is_nan(input logic [FP_W-1:0] v);
        return (&v[FP_W-2:MAN_W]) && (|v[MAN_W-1:0]);
    endfunction

    function automatic logic is_inf(input logic [FP_W-1:0] v);
        return (&v[FP_W-2:MAN_W]) && !(|v[MAN_W-1:0]);
    endfunction

endpackage

// File: rtl/fp_stream_accumulator_adder.sv
// floatingPointAdder: combinational IEEE-754 single add, round-to-nearest-even,
// subnormals supported, any NaN result returned as the canonical quiet NaN.
module floatingPointAdder
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] x,
    input  logic [FP_W-1:0] y,
    output logic [FP_W-1:0] sum
);

    localparam int GW = MAN_W + 4;  // hidden bit, mantissa, guard, round, sticky

    logic [FP_W-1:0]  a, b;
    logic [EXP_W-1:0] ea, eb, d, sh, lz, e_fld;
    logic [MAN_W:0]   ma, mb;
    logic [GW-1:0]    ma_x, mb_al, mb_x, n;
    logic [GW:0]      s;
    logic [EXP_W+1:0] e;
    logic [FP_W-2:0]  mag;
    logic             rnd, sticky;

    always_comb begin
        // a always carries the larger magnitude, so ea >= eb and the result sign is a's
        if (x[FP_W-2:0] >= y[FP_W-2:0]) begin
            a = x;
            b = y;
        end else begin
            a = y;
            b = x;
        end
        ea     = (a[FP_W-2:MAN_W] == '0) ? 8'd1 : a[FP_W-2:MAN_W];
        eb     = (b[FP_W-2:MAN_W] == '0) ? 8'd1 : b[FP_W-2:MAN_W];
        ma     = {|a[FP_W-2:MAN_W], a[MAN_W-1:0]};
        mb     = {|b[FP_W-2:MAN_W], b[MAN_W-1:0]};
        d      = ea - eb;
        ma_x   = {ma, 3'b000};
        mb_al  = {mb, 3'b000};
        sticky = 1'b0;
        if (d >= 8'(GW)) begin
            mb_x = {{(GW-1){1'b0}}, |mb};
        end else begin
            mb_x    = mb_al >> d;
            sticky  = |(mb_al & ~({GW{1'b1}} << d));
            mb_x[0] = mb_x[0] | sticky;
        end

        if (a[FP_W-1] == b[FP_W-1]) s = {1'b0, ma_x} + {1'b0, mb_x};
        else                        s = {1'b0, ma_x} - {1'b0, mb_x};

        lz = 8'(GW);
        for (int i = 0; i < GW; i++) begin
            if (s[i]) lz = 8'(GW - 1 - i);
        end

        // Left shifts stop at the minimum exponent so tiny results land as subnormals
        if (s[GW]) begin
            n  = s[GW:1] | {{(GW-1){1'b0}}, s[0]};
            e  = {2'b00, ea} + 10'd1;
            sh = '0;
        end else begin
            sh = (lz < ea) ? lz : ea - 8'd1;
            n  = s[GW-1:0] << sh;
            e  = {2'b00, ea} - {2'b00, sh};
        end

        rnd   = n[2] & (n[1] | n[0] | n[3]);
        e_fld = n[GW-1] ? e[EXP_W-1:0] : '0;
        // Rounding carry ripples into the exponent: handles mantissa overflow,
        // subnormal-to-normal promotion and overflow to infinity in one add.
        mag   = {e_fld, n[GW-2:3]} + {{(FP_W-2){1'b0}}, rnd};

        if (e >= 10'd255) sum = FP_POS_INF | {a[FP_W-1], {(FP_W-1){1'b0}}};
        else              sum = {a[FP_W-1], mag};
        if (s == '0)      sum = {a[FP_W-1] & b[FP_W-1], {(FP_W-1){1'b0}}};
        if (is_inf(a))    sum = FP_POS_INF | {a[FP_W-1], {(FP_W-1){1'b0}}};
        if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && (x[FP_W-1] != y[FP_W-1])))
            sum = FP_QNAN;
    end

endmodule

// File: rtl/fp_stream_accumulator.sv
// Packet-summing accumulator around one floatingPointAdder in a feedback loop.
// Optional sticky NaN/Inf flags are built when FP_ACC_STICKY_FLAGS_EN is defined.
module fp_stream_accumulator #(
    parameter int FP_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_inf
);
    import fp_pkg::*;

    acc_state_e       state_q, state_d;
    logic [FP_W-1:0]  acc_q, acc_d, out_sum_q, out_sum_d, add_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, out_count_q, out_count_d;

    floatingPointAdder u_add (
        .x   (acc_q),
        .y   (in_data),
        .sum (add_sum)
    );

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        out_sum_d   = add_sum;
                        out_count_d = cnt_inc;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = FP_POS_ZERO;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= FP_POS_ZERO;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

`ifdef FP_ACC_STICKY_FLAGS_EN
    logic nan_q, nan_d, inf_q, inf_d;

    always_comb begin
        nan_d = nan_q;
        inf_d = inf_q;
        if (state_q == ACC && in_valid) begin
            nan_d = nan_q | is_nan(in_data) | is_nan(add_sum);
            inf_d = inf_q | is_inf(in_data) | is_inf(add_sum);
        end else if (state_q == HOLD && out_ready) begin
            nan_d = 1'b0;
            inf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_q <= 1'b0;
            inf_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
            inf_q <= inf_d;
        end
    end

    // Partial flags stay hidden until the packet result is presented
    assign out_nan = nan_q & out_valid;
    assign out_inf = inf_q & out_valid;
`else
    assign out_nan = 1'b0;
    assign out_inf = 1'b0;
`endif

endmodule

// File: doc/fp_stream_accumulator.md
Name: fp_stream_accumulator

Overview:
- Sequential accumulator directly downstream of the operand stream feeding floatingPointAdder.
- Sums a packet of IEEE-754 single-precision values using one combinational floatingPointAdder instance in a feedback loop.
- Inputs arrive on a valid/ready stream, delimited by in_last. Emits one registered sum per packet with a beat count.

Parameters:
- FP_W, 32, float width; fixed at 32, no other value supported.
- CNT_W, 16, width of the per-packet beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  FP_W  IEEE-754 single operand.
- in_last  input  1  final beat of packet; qualified by in_valid.
- out_valid  output  1  packet sum available.
- out_ready  input  1  downstream accepts sum.
- out_sum  output  FP_W  accumulated packet sum.
- out_count  output  CNT_W  beats in packet, saturating.
- out_nan  output  1  sticky NaN seen in packet; feature-gated.
- out_inf  output  1  sticky infinity seen in packet; feature-gated.

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset values: state=ACC, acc=32'h00000000, cnt=0, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_nan=0, out_inf=0.
- States:
  - ACC: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Beat accept: in_valid && in_ready.
  - acc <= floatingPointAdder(acc, in_data).
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
- Last beat (accept with in_last=1):
  - out_sum <= adder(acc, in_data); out_count <= cnt+1 (saturated); state -> HOLD.
  - out_valid rises the next cycle. Latency is 1 cycle from last-beat accept.
- HOLD:
  - out_sum, out_count and flags are stable until out_valid && out_ready.
  - On that handshake: acc <= +0, cnt <= 0, flags clear, out_valid <= 0, state -> ACC.
  - in_ready returns the following cycle. There is no same-cycle accept of a new beat.
- Single-beat packet: out_sum = adder(+0, x) = x, out_count = 1.
- Arithmetic: special cases are exactly as produced by floatingPointAdder.
  - Overflow saturates to +/-Inf (32'h7F800000 / 32'hFF800000).
  - NaN propagates.
  - Exact cancellation gives +0.
- Accumulation state: acc is never exposed except through out_sum.
- Reset mid-packet: the partial sum and count are discarded; the block is in ACC with acc=+0 immediately.
- in_valid while in HOLD: ignored (in_ready=0). The source must hold data per valid/ready rules.
- An empty packet cannot exist; every packet has at least one beat.

Optional Feature:
- Macro: FP_ACC_STICKY_FLAGS_EN.
- Defined:
  - out_nan sets when any accepted in_data or any intermediate sum is NaN (exp=8'hFF, mantissa!=0).
  - out_inf sets when any accepted in_data or any intermediate sum is infinity (exp=8'hFF, mantissa=0).
  - Both are sticky for the packet, valid with out_valid, and cleared on the output handshake or reset.
- Not defined: out_nan and out_inf are tied to 0; no flag logic is synthesised.

Decomposition:
- Package fp_pkg:
  - FP_W=32, EXP_W=8, MAN_W=23.
  - Constants FP_POS_ZERO=32'h00000000, FP_POS_INF=32'h7F800000, FP_NEG_INF=32'hFF800000, FP_QNAN=32'h7FC00000.
  - Helper functions is_nan, is_inf.
  - State enum {ACC, HOLD}.
- Sub-module: the existing floatingPointAdder, instantiated once with x=acc, y=in_data. No other sub-module.

Test Plan:
- Beats 32'h3F800000, 32'h3F800000, 32'h3F800000(last) -> out_sum=32'h40400000 (3.0), out_count=3, out_valid one cycle after last accept.
- 32'h3F000000, then 32'hBF800000(last) -> out_sum=32'hBF000000 (-0.5), count=2. Next single-beat packet 32'h3F800000(last) -> out_sum=32'h3F800000, count=1 (acc cleared).
- Backpressure: out_ready=0 for 5 cycles after sum -> in_ready=0 throughout, out_sum/out_count stable; out_ready=1 -> out_valid falls next cycle, in_ready=1.
- 32'h7F000000, 32'h7F000000(last) -> out_sum=32'h7F800000; with FP_ACC_STICKY_FLAGS_EN out_inf=1, out_nan=0.
- 32'h7FC00000, 32'h3F800000(last) -> out_sum NaN (exp=FF, man!=0); with the macro, out_nan=1. Next packet flags read 0.
- Assert rst_n low after two beats of 1.0, release, send 32'h3F800000(last) -> out_sum=32'h3F800000, count=1; all outputs 0 during reset.
